// File: rtl/carpark_pkg.sv
// Shared constants and types for the car-park entry gate controller.
package carpark_pkg;

    localparam logic [1:0] PARK_OK  = 2'b00;
    localparam logic [1:0] PARK_BAD = 2'b01;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOpen = 2'd1,
        StDeny = 2'd2,
        StLock = 2'd3
    } gate_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/carpark_occ_counter.sv
// Saturating occupancy counter with a registered full flag.
module carpark_occ_counter #(
    parameter int unsigned CAPACITY = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          inc,
    input  logic                          dec,
    output logic [$clog2(CAPACITY+1)-1:0] count,
    output logic                          full
);

    localparam int unsigned CntW = $clog2(CAPACITY + 1);
    localparam logic [CntW-1:0] Cap = CntW'(CAPACITY);

    logic [CntW-1:0] count_q, count_d;
    logic            full_q, full_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && count_q != Cap) begin
            count_d = count_q + CntW'(1);
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - CntW'(1);
        end
        full_d = (count_d == Cap);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign count = count_q;
    assign full  = full_q;

endmodule

// File: rtl/carpark_gate_ctrl.sv
// Car-park entry gate FSM: grant/deny handling, timed gate, occupancy tracking.
// Optional repeated-denial lockout is built when CARPARK_LOCKOUT_EN is defined.
module carpark_gate_ctrl
    import carpark_pkg::*;
#(
    parameter int unsigned CAPACITY    = 8,
    parameter int unsigned OPEN_CYCLES = 16,
    parameter int unsigned DENY_CYCLES = 4,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYCLES = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0]                    park,
    input  logic                          park_valid,
    input  logic                          car_in,
    input  logic                          car_out,
    output logic                          gate_open,
    output logic                          green,
    output logic                          red,
    output logic [$clog2(CAPACITY+1)-1:0] occupancy,
    output logic                          full,
    output logic                          locked
);

    localparam int unsigned TimerMax = max3(OPEN_CYCLES, DENY_CYCLES, LOCK_CYCLES);
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    localparam logic [TimerW-1:0] OpenLoad = TimerW'(OPEN_CYCLES - 1);
    localparam logic [TimerW-1:0] DenyLoad = TimerW'(DENY_CYCLES - 1);

    gate_state_e       state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              gate_open_q, gate_open_d;
    logic              green_q, green_d;
    logic              red_q, red_d;
    logic              full_deny;
    logic              grant, deny, car_enter, timer_done;
    logic              occ_inc, occ_dec, occ_full;

    assign grant      = park_valid && (park == PARK_OK);
    assign deny       = park_valid && (park == PARK_BAD);
    assign car_enter  = (state_q == StOpen) && car_in;
    assign timer_done = (timer_q == '0);

    // Simultaneous in/out pulses cancel, whether or not the entry itself was accepted.
    assign occ_inc = car_enter && !car_out;
    assign occ_dec = car_out && !car_in;

`ifdef CARPARK_LOCKOUT_EN
    localparam int unsigned FailW = $clog2(MAX_FAILS + 1);
    localparam logic [TimerW-1:0] LockLoad = TimerW'(LOCK_CYCLES - 1);

    logic [FailW-1:0] fail_q, fail_d;
    logic             lock_hit;
    logic             locked_q, locked_d;

    assign lock_hit = ((fail_q + FailW'(1)) == FailW'(MAX_FAILS));
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        full_deny = 1'b0;
`ifdef CARPARK_LOCKOUT_EN
        fail_d    = fail_q;
`endif
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (grant && !occ_full) begin
                    state_d = StOpen;
                    timer_d = OpenLoad;
`ifdef CARPARK_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end else if (grant) begin
                    full_deny = 1'b1;
                end else if (deny) begin
`ifdef CARPARK_LOCKOUT_EN
                    fail_d = fail_q + FailW'(1);
                    if (lock_hit) begin
                        state_d = StLock;
                        timer_d = LockLoad;
                    end else begin
                        state_d = StDeny;
                        timer_d = DenyLoad;
                    end
`else
                    state_d = StDeny;
                    timer_d = DenyLoad;
`endif
                end
            end
            StOpen: begin
                if (car_enter || timer_done) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StDeny: begin
                if (timer_done) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StLock: begin
                if (timer_done) begin
                    state_d = StIdle;
`ifdef CARPARK_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        gate_open_d = (state_d == StOpen);
        green_d     = (state_d == StOpen);
        red_d       = (state_d == StDeny) || (state_d == StLock) || full_deny;
`ifdef CARPARK_LOCKOUT_EN
        locked_d    = (state_d == StLock);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            gate_open_q <= 1'b0;
            green_q     <= 1'b0;
            red_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            gate_open_q <= gate_open_d;
            green_q     <= green_d;
            red_q       <= red_d;
        end
    end

`ifdef CARPARK_LOCKOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fail_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            fail_q   <= fail_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    carpark_occ_counter #(
        .CAPACITY (CAPACITY)
    ) u_occ (
        .clock (clock),
        .reset (reset),
        .inc   (occ_inc),
        .dec   (occ_dec),
        .count (occupancy),
        .full  (occ_full)
    );

    assign full      = occ_full;
    assign gate_open = gate_open_q;
    assign green     = green_q;
    assign red       = red_q;

endmodule

// File: tb/tb_carpark_gate_ctrl.sv
// Self-checking bench for carpark_gate_ctrl: directed scenarios plus random traffic vs a model.
module tb_carpark_gate_ctrl;
    import carpark_pkg::*;

    localparam int CAP    = 8;
    localparam int OPEN_N = 16;
    localparam int DENY_N = 4;
    localparam int MAXF   = 3;
    localparam int LOCK_N = 64;
    localparam int OCC_W  = $clog2(CAP + 1);

`ifdef CARPARK_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    localparam int P_IDLE = 0;
    localparam int P_OPEN = 1;
    localparam int P_DENY = 2;
    localparam int P_LOCK = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       park = 2'b00;
    logic             park_valid = 1'b0;
    logic             car_in = 1'b0;
    logic             car_out = 1'b0;
    logic             gate_open, green, red, full, locked;
    logic [OCC_W-1:0] occupancy;

    int errors = 0;
    int checks = 0;

    // Reference model: phase, cycles remaining in it (including the current one), cars, fails.
    int m_phase = P_IDLE;
    int m_left  = 0;
    int m_occ   = 0;
    int m_fails = 0;
    bit m_redpulse = 1'b0;

    carpark_gate_ctrl #(
        .CAPACITY    (CAP),
        .OPEN_CYCLES (OPEN_N),
        .DENY_CYCLES (DENY_N),
        .MAX_FAILS   (MAXF),
        .LOCK_CYCLES (LOCK_N)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .park       (park),
        .park_valid (park_valid),
        .car_in     (car_in),
        .car_out    (car_out),
        .gate_open  (gate_open),
        .green      (green),
        .red        (red),
        .occupancy  (occupancy),
        .full       (full),
        .locked     (locked)
    );

    always #5 clock = ~clock;

    task automatic model_step();
        bit was_full;
        if (reset) begin
            m_phase = P_IDLE;
            m_left = 0;
            m_occ = 0;
            m_fails = 0;
            m_redpulse = 1'b0;
            return;
        end
        was_full = (m_occ == CAP);
        m_redpulse = 1'b0;
        if (!(car_in && car_out)) begin
            if (car_in && m_phase == P_OPEN && m_occ < CAP) m_occ++;
            else if (car_out && m_occ > 0) m_occ--;
        end
        case (m_phase)
            P_IDLE: begin
                if (park_valid && park == PARK_OK) begin
                    if (was_full) begin
                        m_redpulse = 1'b1;
                    end else begin
                        m_phase = P_OPEN;
                        m_left = OPEN_N;
                        m_fails = 0;
                    end
                end else if (park_valid && park == PARK_BAD) begin
                    m_fails++;
                    if (LOCKOUT && m_fails >= MAXF) begin
                        m_phase = P_LOCK;
                        m_left = LOCK_N;
                    end else begin
                        m_phase = P_DENY;
                        m_left = DENY_N;
                    end
                end
            end
            P_OPEN: begin
                m_left--;
                if (car_in || m_left == 0) m_phase = P_IDLE;
            end
            P_DENY: begin
                m_left--;
                if (m_left == 0) m_phase = P_IDLE;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = P_IDLE;
                    m_fails = 0;
                end
            end
        endcase
    endtask

    // Inputs are applied at the falling edge, consumed at the rising edge, sampled at the next fall.
    task automatic cycle(input logic [1:0] pk, input logic pv, input logic ci, input logic co);
        park = pk;
        park_valid = pv;
        car_in = ci;
        car_out = co;
        @(posedge clock);
        model_step();
        @(negedge clock);
        park_valid = 1'b0;
        car_in = 1'b0;
        car_out = 1'b0;
    endtask

    task automatic idle_cycle();
        cycle(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_cycle();
        idle_cycle();
        checks++;
        if ({gate_open, green, red, locked, full} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {gate_open, green, red, locked, full});
        end
        checks++;
        if (occupancy !== '0) begin
            errors++;
            $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
        end
        reset = 1'b0;
        idle_cycle();
        checks++;
        if ({gate_open, red} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got %b expected 00", {gate_open, red});
        end
    endtask

    task automatic test_grant_car_in();
        int n;
        n = 0;
        cycle(PARK_OK, 1'b1, 1'b0, 1'b0);
        checks++;
        if (green !== 1'b1) begin
            errors++;
            $display("FAIL grant_green: got %b expected 1", green);
        end
        if (gate_open === 1'b1) n++;
        repeat (4) begin
            idle_cycle();
            if (gate_open === 1'b1) n++;
        end
        cycle(2'b00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL grant_open_cycles: got %0d expected 5", n);
        end
        checks++;
        if (gate_open !== 1'b0) begin
            errors++;
            $display("FAIL grant_closed_after_car: got %b expected 0", gate_open);
        end
        checks++;
        if (occupancy !== OCC_W'(1)) begin
            errors++;
            $display("FAIL grant_occupancy: got %0d expected 1", occupancy);
        end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        cycle(PARK_OK, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && gate_open === 1'b1; i++) begin
            n++;
            idle_cycle();
        end
        checks++;
        if (n !== OPEN_N) begin
            errors++;
            $display("FAIL timeout_open_cycles: got %0d expected %0d", n, OPEN_N);
        end
        checks++;
        if (occupancy !== OCC_W'(1)) begin
            errors++;
            $display("FAIL timeout_occupancy: got %0d expected 1", occupancy);
        end
    endtask

    task automatic deny_and_measure(output int red_n, output int locked_n, output int gate_n);
        cycle(PARK_BAD, 1'b1, 1'b0, 1'b0);
        red_n = 0;
        locked_n = 0;
        gate_n = 0;
        for (int i = 0; i < 200 && red === 1'b1; i++) begin
            red_n++;
            if (locked === 1'b1) locked_n++;
            if (gate_open === 1'b1) gate_n++;
            if (i == 10) cycle(PARK_OK, 1'b1, 1'b0, 1'b0);
            else idle_cycle();
        end
    endtask

    task automatic test_lockout();
        int r, l, g;
        int exp_r3, exp_l3;
        exp_r3 = LOCKOUT ? LOCK_N : DENY_N;
        exp_l3 = LOCKOUT ? LOCK_N : 0;
        for (int k = 1; k <= 2; k++) begin
            deny_and_measure(r, l, g);
            checks++;
            if (r !== DENY_N || l !== 0) begin
                errors++;
                $display("FAIL deny%0d_period: got red=%0d locked=%0d expected red=%0d locked=0",
                         k, r, l, DENY_N);
            end
        end
        deny_and_measure(r, l, g);
        checks++;
        if (r !== exp_r3) begin
            errors++;
            $display("FAIL deny3_red_cycles: got %0d expected %0d", r, exp_r3);
        end
        checks++;
        if (l !== exp_l3) begin
            errors++;
            $display("FAIL deny3_locked_cycles: got %0d expected %0d", l, exp_l3);
        end
        checks++;
        if (g !== 0 || gate_open !== 1'b0) begin
            errors++;
            $display("FAIL lock_grant_ignored: got gate cycles %0d expected 0", g);
        end
        deny_and_measure(r, l, g);
        checks++;
        if (r !== DENY_N || l !== 0) begin
            errors++;
            $display("FAIL deny_after_lock: got red=%0d locked=%0d expected red=%0d locked=0",
                     r, l, DENY_N);
        end
    endtask

    task automatic test_full();
        repeat (CAP - 1) begin
            cycle(PARK_OK, 1'b1, 1'b0, 1'b0);
            cycle(2'b00, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (occupancy !== OCC_W'(CAP) || full !== 1'b1) begin
            errors++;
            $display("FAIL fill: got occ=%0d full=%b expected occ=%0d full=1", occupancy, full, CAP);
        end
        cycle(PARK_OK, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({red, gate_open, green} !== 3'b100) begin
            errors++;
            $display("FAIL full_grant: got red/gate/green=%b expected 100", {red, gate_open, green});
        end
        idle_cycle();
        checks++;
        if ({red, gate_open} !== 2'b00) begin
            errors++;
            $display("FAIL full_red_pulse_len: got red/gate=%b expected 00", {red, gate_open});
        end
        cycle(2'b00, 1'b0, 1'b1, 1'b1);
        checks++;
        if (occupancy !== OCC_W'(CAP)) begin
            errors++;
            $display("FAIL full_in_out_same: got %0d expected %0d", occupancy, CAP);
        end
        repeat (CAP) cycle(2'b00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (occupancy !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL drain: got occ=%0d full=%b expected occ=0 full=0", occupancy, full);
        end
        cycle(2'b00, 1'b0, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (occupancy !== '0) begin
            errors++;
            $display("FAIL empty_saturate: got %0d expected 0", occupancy);
        end
    endtask

    task automatic test_reset_mid_open();
        cycle(PARK_OK, 1'b1, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 1'b0);
        cycle(PARK_OK, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
        checks++;
        if (gate_open !== 1'b1 || occupancy !== OCC_W'(1)) begin
            errors++;
            $display("FAIL pre_reset_open: got gate=%b occ=%0d expected gate=1 occ=1",
                     gate_open, occupancy);
        end
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        checks++;
        if ({gate_open, green, red, locked, full} !== 5'b0 || occupancy !== '0) begin
            errors++;
            $display("FAIL mid_open_reset: got flags=%b occ=%0d expected flags=00000 occ=0",
                     {gate_open, green, red, locked, full}, occupancy);
        end
        cycle(PARK_OK, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({gate_open, green} !== 2'b11) begin
            errors++;
            $display("FAIL post_reset_grant: got %b expected 11", {gate_open, green});
        end
        cycle(2'b00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (occupancy !== OCC_W'(1) || gate_open !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_entry: got occ=%0d gate=%b expected occ=1 gate=0",
                     occupancy, gate_open);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
            checks++;
            if (gate_open !== (m_phase == P_OPEN)) begin
                errors++;
                $display("FAIL rand_gate_open @%0d: got %b expected %b", c, gate_open,
                         (m_phase == P_OPEN));
            end
            checks++;
            if (green !== (m_phase == P_OPEN)) begin
                errors++;
                $display("FAIL rand_green @%0d: got %b expected %b", c, green,
                         (m_phase == P_OPEN));
            end
            checks++;
            if (red !== (m_phase == P_DENY || m_phase == P_LOCK || m_redpulse)) begin
                errors++;
                $display("FAIL rand_red @%0d: got %b expected %b", c, red,
                         (m_phase == P_DENY || m_phase == P_LOCK || m_redpulse));
            end
            checks++;
            if (locked !== (m_phase == P_LOCK)) begin
                errors++;
                $display("FAIL rand_locked @%0d: got %b expected %b", c, locked,
                         (m_phase == P_LOCK));
            end
            checks++;
            if (occupancy !== OCC_W'(m_occ)) begin
                errors++;
                $display("FAIL rand_occupancy @%0d: got %0d expected %0d", c, occupancy, m_occ);
            end
            checks++;
            if (full !== (m_occ == CAP)) begin
                errors++;
                $display("FAIL rand_full @%0d: got %b expected %b", c, full, (m_occ == CAP));
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_grant_car_in();
        test_timeout();
        test_lockout();
        test_full();
        test_reset_mid_open();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/carpark_gate_ctrl.md
CARPARK_GATE_CTRL -- requirements
Module: carpark_gate_ctrl

Interface
REQ-001 Parameter CAPACITY, default 8: number of parking slots.
REQ-002 Parameter OPEN_CYCLES, default 16: maximum cycles the gate stays open waiting for a car.
REQ-003 Parameter DENY_CYCLES, default 4: cycles the red indicator is held after a denial.
REQ-004 Parameter MAX_FAILS, default 3: consecutive denials that trigger lockout.
REQ-005 Parameter LOCK_CYCLES, default 64: lockout duration in cycles.
REQ-006 clock  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 park  input  2  verdict code from the password stage: 2'b00 granted, 2'b01 denied, 2'b10 and 2'b11 ignored.
REQ-009 park_valid  input  1  single-cycle strobe; park is sampled only when this is high.
REQ-010 car_in  input  1  single-cycle pulse: car passed the entry gate.
REQ-011 car_out  input  1  single-cycle pulse: car left through the exit.
REQ-012 gate_open  output  1  entry barrier raise command.
REQ-013 green  output  1  access-granted indicator.
REQ-014 red  output  1  denial or lockout indicator.
REQ-015 occupancy  output  $clog2(CAPACITY+1)  number of cars inside.
REQ-016 full  output  1  high when occupancy equals CAPACITY.
REQ-017 locked  output  1  high during lockout.

Function
REQ-018 The FSM SHALL have the states IDLE, OPEN, DENY and LOCK, and all outputs SHALL be registered.
REQ-019 In IDLE, a granted verdict with full low SHALL move to OPEN on the next cycle.
- gate_open and green SHALL be high for the whole of OPEN.
- The fail count SHALL clear.
REQ-020 In IDLE, a granted verdict with full high SHALL hold IDLE.
- red SHALL go high for exactly 1 cycle.
- The fail count SHALL be unchanged.
REQ-021 In IDLE, a denied verdict SHALL increment the fail count.
- If the new count equals MAX_FAILS, the FSM SHALL go to LOCK; otherwise it SHALL go to DENY.
REQ-022 OPEN SHALL return to IDLE on car_in, or after OPEN_CYCLES cycles, whichever comes first.
- A timeout SHALL NOT change occupancy.
REQ-023 DENY SHALL hold red high for DENY_CYCLES cycles, then return to IDLE.
REQ-024 LOCK SHALL hold red and locked high for LOCK_CYCLES cycles, then return to IDLE with the fail count cleared.
REQ-025 park_valid SHALL be ignored in OPEN, DENY and LOCK, and ignored codes SHALL cause no state change.
REQ-026 Occupancy rules:
- car_in accepted only in OPEN increments occupancy.
- car_out decrements occupancy.
- car_in and car_out in the same cycle leave occupancy unchanged.
- Occupancy saturates at 0 and at CAPACITY (no wrap).
REQ-027 A single down-counter SHALL time OPEN, DENY and LOCK, and it SHALL be reloaded on each state entry.

Reset
REQ-028 While reset is high, the block SHALL be in IDLE with:
- occupancy = 0, fail count = 0, timer = 0;
- gate_open = 0, green = 0, red = 0, locked = 0, full = 0.
REQ-029 Reset asserted mid-OPEN or mid-LOCK SHALL abort the state and clear occupancy at the next clock edge.

Configuration
REQ-030 When CARPARK_LOCKOUT_EN is defined, the fail count, the LOCK state and the locked output SHALL behave as specified above.
REQ-031 When CARPARK_LOCKOUT_EN is undefined:
- Every denial SHALL go to DENY.
- No fail counter SHALL be synthesized.
- locked SHALL be tied to 0.

Structure
REQ-032 Package carpark_pkg SHALL hold:
- the park code constants PARK_OK = 2'b00 and PARK_BAD = 2'b01;
- the FSM state enum type.
REQ-033 The occupancy counter SHALL be a sub-module carpark_occ_counter (inc, dec, count, full), parameterised by CAPACITY.

Verification
REQ-034 Grant with occupancy 0, then car_in 5 cycles later -> gate_open high for exactly 5 cycles, then occupancy = 1.
REQ-035 Grant with no car_in -> gate_open drops after 16 cycles and occupancy is unchanged.
REQ-036 Three consecutive denials -> DENY, DENY, then LOCK: locked high for 64 cycles and a grant during lockout is ignored.
- Without CARPARK_LOCKOUT_EN the same stimulus gives three DENY periods and locked stays 0.
REQ-037 Fill to occupancy 8, then grant -> full = 1, red pulses 1 cycle and the gate stays closed.
- car_in and car_out in the same cycle leave occupancy at 8.
- car_out at occupancy 0 leaves it at 0.
REQ-038 reset asserted in the 3rd cycle of OPEN -> all outputs 0 and occupancy 0 at the next edge, then a normal grant works.
